// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Bundles the game controller's status inputs and its control/score
//   outputs so the sequencer, the pipe datapath and the overlays can share
//   one connection.
//   Inputs to the sequencer : fresh, START, score_out, collide, ground_hit
//   Outputs of the sequencer: game_status, pipe_reset, speed[3:0],
//                             score[15:0], high_score[15:0], state[1:0]
//   master = the sequencer itself; slave = whoever feeds and observes it.
interface game_sequencer_if;
  logic        fresh;
  logic        START;
  logic        score_out;
  logic        collide;
  logic        ground_hit;
  logic        game_status;
  logic        pipe_reset;
  logic [3:0]  speed;
  logic [15:0] score;
  logic [15:0] high_score;
  logic [1:0]  state;

  modport master (
    input  fresh, START, score_out, collide, ground_hit,
    output game_status, pipe_reset, speed, score, high_score, state
  );

  modport slave (
    output fresh, START, score_out, collide, ground_hit,
    input  game_status, pipe_reset, speed, score, high_score, state
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level game controller. Walks IDLE -> PLAY -> DYING -> OVER -> IDLE,
//   starts/stops pipe motion, holds the pipe block in reset while idle,
//   raises scroll speed as points accumulate and keeps a packed-BCD score
//   plus the best score since RESET.
//   Ports:
//     clk   - pixel-domain clock
//     RESET - asynchronous, active-high reset
//     bus   - game_sequencer_if.master (status in, control/score out)
module game_sequencer #(
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX  = 8,
  parameter int SPEED_STEP = 5,
  parameter int DIE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             RESET,
  game_sequencer_if.master bus
);

  if (SPEED_MAX > 15 || SPEED_MAX < 0) begin : g_bad_speed_max
    $error("game_sequencer: SPEED_MAX must fit in 4 bits");
  end
  if (SPEED_INIT > SPEED_MAX || SPEED_INIT < 0) begin : g_bad_speed_init
    $error("game_sequencer: SPEED_INIT must lie in 0..SPEED_MAX");
  end
  if (SPEED_STEP < 1) begin : g_bad_speed_step
    $error("game_sequencer: SPEED_STEP must be at least 1");
  end
  if (DIE_FRAMES < 1 || DIE_FRAMES > 255) begin : g_bad_die_frames
    $error("game_sequencer: DIE_FRAMES must lie in 1..255");
  end

  localparam int          STEP_W     = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam [STEP_W-1:0] STEP_LAST  = STEP_W'(SPEED_STEP - 1);
  localparam [7:0]        FRAME_LAST = 8'(DIE_FRAMES - 1);
  localparam [3:0]        SPEED_I    = 4'(SPEED_INIT);
  localparam [3:0]        SPEED_M    = 4'(SPEED_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              fresh_q, start_q, score_out_q;
  logic [15:0]       score_q, score_d;
  logic [15:0]       high_score_q, high_score_d;
  logic [3:0]        speed_q, speed_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [7:0]        frame_q, frame_d;

  logic frame_tick, start_rise, pass_rise;

  // Frame boundary is the falling edge of fresh (start of blanking);
  // START and score_out count on their rising edges.
  assign frame_tick = fresh_q & ~bus.fresh;
  assign start_rise = bus.START & ~start_q;
  assign pass_rise  = bus.score_out & ~score_out_q;

  // Packed-BCD +1 with per-digit carry; 9999 sticks rather than wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      fresh_q      <= 1'b0;
      start_q      <= 1'b0;
      score_out_q  <= 1'b0;
      score_q      <= 16'h0000;
      high_score_q <= 16'h0000;
      speed_q      <= SPEED_I;
      step_q       <= '0;
      frame_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      fresh_q      <= bus.fresh;
      start_q      <= bus.START;
      score_out_q  <= bus.score_out;
      score_q      <= score_d;
      high_score_q <= high_score_d;
      speed_q      <= speed_d;
      step_q       <= step_d;
      frame_q      <= frame_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_score_d = high_score_q;
    speed_d      = speed_q;
    step_d       = step_q;
    frame_d      = frame_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = PLAY;
          score_d = 16'h0000;
          speed_d = SPEED_I;
          step_d  = '0;
        end
      end
      PLAY: begin
        // A collision in the same cycle as a pipe pass forfeits that point.
        if (bus.collide || bus.ground_hit) begin
          state_d = DYING;
          frame_d = 8'd0;
        end else if (pass_rise) begin
          score_d = bcd_inc(score_q);
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (speed_q < SPEED_M) begin
              speed_d = speed_q + 4'd1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (frame_q == FRAME_LAST) begin
            state_d = OVER;
            // Packed BCD orders the same as its decimal value.
            if (score_q > high_score_q) begin
              high_score_d = score_q;
            end
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.game_status = (state_q == PLAY);
  assign bus.pipe_reset  = (state_q == IDLE);
  assign bus.speed       = speed_q;
  assign bus.score       = score_q;
  assign bus.high_score  = high_score_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Directed bench for game_sequencer. A behavioural model of the game rules
//   predicts every output after each clock; predictions are queued when the
//   inputs are driven and popped once the DUT has clocked them in.
module tb_game_sequencer;

  typedef struct packed {
    logic [1:0]  state;
    logic        game_status;
    logic        pipe_reset;
    logic [3:0]  speed;
    logic [15:0] score;
    logic [15:0] high_score;
  } exp_t;

  logic clk;
  logic RESET;
  game_sequencer_if bus ();

  game_sequencer dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  // Model state: whole-game view in decimal, independent of BCD digit logic.
  int m_state;
  int m_passes;
  int m_high;
  int m_frames;
  logic m_prev_start, m_prev_pass, m_prev_fresh;

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    int   s;
    s             = 2 + m_passes / 5;
    e.state       = 2'(m_state);
    e.game_status = (m_state == 1);
    e.pipe_reset  = (m_state == 0);
    e.speed       = 4'((s > 8) ? 8 : s);
    e.score       = to_bcd(m_passes);
    e.high_score  = to_bcd(m_high);
    return e;
  endfunction

  task automatic model_reset();
    m_state      = 0;
    m_passes     = 0;
    m_high       = 0;
    m_frames     = 0;
    m_prev_start = 1'b0;
    m_prev_pass  = 1'b0;
    m_prev_fresh = 1'b0;
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failed++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      cmp("state",       16'(bus.state),       16'(e.state));
      cmp("game_status", 16'(bus.game_status), 16'(e.game_status));
      cmp("pipe_reset",  16'(bus.pipe_reset),  16'(e.pipe_reset));
      cmp("speed",       16'(bus.speed),       16'(e.speed));
      cmp("score",       bus.score,            e.score);
      cmp("high_score",  bus.high_score,       e.high_score);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue its prediction,
  // clock the DUT and compare.
  task automatic apply_stimulus(input logic st, input logic so, input logic co,
                                input logic gh, input logic fr);
    logic s_rise, p_rise, tick;
    bus.START      = st;
    bus.score_out  = so;
    bus.collide    = co;
    bus.ground_hit = gh;
    bus.fresh      = fr;
    s_rise = st & ~m_prev_start;
    p_rise = so & ~m_prev_pass;
    tick   = m_prev_fresh & ~fr;
    case (m_state)
      0: if (s_rise) begin m_state = 1; m_passes = 0; end
      1: begin
        if (co || gh) begin
          m_state  = 2;
          m_frames = 0;
        end else if (p_rise) begin
          m_passes++;
        end
      end
      2: if (tick) begin
        m_frames++;
        if (m_frames == 60) begin
          m_state = 3;
          if (((m_passes > 9999) ? 9999 : m_passes) > m_high)
            m_high = (m_passes > 9999) ? 9999 : m_passes;
        end
      end
      default: if (s_rise) m_state = 0;
    endcase
    m_prev_start = st;
    m_prev_pass  = so;
    m_prev_fresh = fr;
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic passes(input logic st, input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(st, 1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(st, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic frames(input logic st, input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(st, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_stimulus(st, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // From OVER: one START rise back to IDLE, hold START, then a fresh rise to play.
  task automatic restart_game();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("over_to_idle_pipe_reset", 16'(bus.pipe_reset), 16'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("held_start_stays_idle", 16'(bus.state), 16'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("restart_state", 16'(bus.state), 16'd1);
  endtask

  initial begin
    bus.START      = 1'b0;
    bus.score_out  = 1'b0;
    bus.collide    = 1'b0;
    bus.ground_hit = 1'b0;
    bus.fresh      = 1'b0;
    RESET          = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b0;
    exp_q.push_back(model_outputs());
    check_output();

    // Game 1: start, three passes, then a pass coinciding with a collision.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("start_speed", 16'(bus.speed), 16'd2);
    passes(1'b1, 3);
    cmp("g1_score", bus.score, 16'h0003);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("pass_with_collide_score", bus.score, 16'h0003);
    cmp("pass_with_collide_state", 16'(bus.state), 16'd2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frames(1'b1, 59);
    cmp("dying_after_59", 16'(bus.state), 16'd2);
    frames(1'b1, 1);
    cmp("over_after_60", 16'(bus.state), 16'd3);
    cmp("g1_high", bus.high_score, 16'h0003);

    // Game 2: lower score ending on ground hit leaves the best score alone.
    restart_game();
    passes(1'b1, 2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frames(1'b1, 60);
    cmp("g2_high_kept", bus.high_score, 16'h0003);

    // Game 3: BCD carries, speed steps and saturation of speed and score.
    restart_game();
    passes(1'b1, 5);
    cmp("speed_after_5", 16'(bus.speed), 16'd3);
    passes(1'b1, 4);
    cmp("score_9", bus.score, 16'h0009);
    passes(1'b1, 1);
    cmp("score_10", bus.score, 16'h0010);
    cmp("speed_after_10", 16'(bus.speed), 16'd4);
    passes(1'b1, 25);
    cmp("speed_sat", 16'(bus.speed), 16'd8);
    passes(1'b1, 9999 - 35);
    cmp("score_9999", bus.score, 16'h9999);
    passes(1'b1, 1);
    cmp("score_hold_9999", bus.score, 16'h9999);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frames(1'b1, 60);
    cmp("g3_high", bus.high_score, 16'h9999);

    // Game 4: asynchronous reset mid-play takes effect without a clock edge.
    restart_game();
    passes(1'b1, 12);
    cmp("g4_score", bus.score, 16'h0012);
    #1;
    RESET = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_outputs());
    check_output();
    cmp("async_reset_high", bus.high_score, 16'h0000);
    bus.START = 1'b0;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller FSM that sequences the pipe datapath: starts and stops pipe motion (game_status), drives the pipe reset, selects scroll speed, and keeps score.
- Consumes the pipe block's score_out pass flag, plus collision and ground-hit flags from the bird/collision logic.
- Produces BCD score and high score for the seven-segment and VGA text overlays.

Parameters:
- SPEED_INIT, 2: speed loaded at game start (pixels/frame).
- SPEED_MAX, 8: speed ceiling.
- SPEED_STEP, 5: points scored per speed increment.
- DIE_FRAMES, 60: frames spent in DYING before OVER (1..255).

Ports:
- clk  in  1  pixel-domain clock (same clock as clkdiv[0]).
- RESET  in  1  asynchronous, active-high reset.
- fresh  in  1  frame strobe, synchronous to clk; its falling edge marks start of blanking.
- START  in  1  start button level (debounced externally).
- score_out  in  1  pipe-pass flag from pipe block; rising edge = one pipe cleared.
- collide  in  1  bird overlaps a pipe column (level).
- ground_hit  in  1  bird reached ground (level).
- game_status  out  1  1 = pipes move; high only in PLAY.
- pipe_reset  out  1  level reset request to pipe block; high only in IDLE.
- speed  out  4  current scroll speed.
- score  out  16  4-digit packed BCD current score.
- high_score  out  16  4-digit packed BCD best score since RESET.
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3 (debug/overlay select).

Behaviour:
- Async reset values:
  - state=IDLE; game_status=0; pipe_reset=1; speed=SPEED_INIT.
  - score=0; high_score=0; all edge-detect regs=0; frame counter=0; step counter=0.
- Edge detection:
  - Registered copies of fresh, START and score_out.
  - frame_tick = fresh_d & ~fresh; start_rise = START & ~START_d; pass_rise = score_out & ~score_out_d.
  - Each strobe is 1 cycle wide; the registered outputs react on the following clock.
- IDLE:
  - Outputs: game_status=0, pipe_reset=1.
  - start_rise → PLAY. In the same transition: score=0, speed=SPEED_INIT, step counter=0.
- PLAY:
  - Outputs: game_status=1, pipe_reset=0.
  - pass_rise increments score in BCD with per-digit carry; 9999 saturates, no wrap.
  - Step counter (0..SPEED_STEP-1) increments on each counted pass. On reaching SPEED_STEP-1 it wraps to 0 and speed += 1 if speed < SPEED_MAX; at SPEED_MAX speed holds.
  - collide | ground_hit (sampled every clk) → DYING, game_status=0 on the next cycle, frame counter=0.
  - A pass_rise in the same cycle as collide/ground_hit is discarded (collision wins).
  - start_rise is ignored.
- DYING:
  - game_status=0 freezes pipes in place; pipe_reset=0 so pipes stay visible.
  - Frame counter increments on each frame_tick. When the counter equals DIE_FRAMES-1 and a frame_tick occurs → OVER.
  - On entry to OVER: high_score = score if score > high_score (unsigned compare of packed BCD is valid).
  - START is ignored.
- OVER:
  - game_status=0, pipe_reset=0.
  - start_rise → IDLE. A second start_rise is then needed to play; START held high does not auto-start.
- Speed changes apply immediately to the output. The pipe block samples speed on its own frame edge, so no extra synchronisation is required.
- Reset mid-operation (any state): immediate return to reset values, including high_score.
- Widths:
  - speed is 4-bit unsigned; SPEED_MAX ≤ 15 is enforced by parameter check.
  - Frame counter is 8-bit.

Test Plan:
- RESET pulse, then START 0→1 → next cycle state=1, game_status=1, pipe_reset=0, speed=2, score=0x0000.
- In PLAY, pulse score_out 9 times → score=0x0009; 10th pulse → 0x0010. After 5th pulse speed=3; after 10th speed=4.
- Force score=0x9999, pulse score_out → score stays 0x9999. Drive 35 passes from 0 → speed saturates at 8.
- score_out rise and collide in same cycle at score=0x0003 → score stays 0x0003, state=2, game_status=0. After exactly 60 frame_ticks → state=3, high_score=0x0003.
- Second game scoring 0x0002 → high_score stays 0x0003. In OVER, START rise → IDLE with pipe_reset=1; START held high causes no further transition.
- Assert RESET asynchronously mid-PLAY with score=0x0012, high_score=0x0007 → all outputs at reset values immediately, without waiting for a clk edge.
